// File: rtl/inpdt_seq.sv
// inpdt_seq: sequencer for a 16-lane inner-product datapath.
// It accepts a job (base address, chunk count), streams one operand chunk per
// cycle out of the operand memory, feeds each returned chunk to the datapath,
// accumulates the signed datapath results and presents the total with a
// valid/ready handshake.
// Optional feature: define INPDT_SEQ_SAT_EN to clamp the reported result to
// the signed 16-bit range [-32768, 32767] (sign-extended to ACC_W).
module inpdt_seq #(
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 29
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic [ADDR_W-1:0]        iBase,
    input  logic [7:0]               iLen,
    input  logic                     iAbort,
    output logic                     oRdEn,
    output logic [ADDR_W-1:0]        oRdAddr,
    input  logic [143:0]             iRdXH,
    input  logic [143:0]             iRdW,
    output logic [143:0]             oDp_XH,
    output logic [143:0]             oDp_W,
    output logic                     oDp_En,
    input  logic signed [20:0]       iDp_Result,
    output logic                     oBusy,
    output logic                     oValid,
    input  logic                     iReady,
    output logic signed [ACC_W-1:0]  oAcc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Final result shaping: optional clamp to the signed 16-bit range.
    function automatic logic signed [ACC_W-1:0] shape_result(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = ACC_W'(32'sd32767);
        min_v = ACC_W'(-32'sd32768);
`ifdef INPDT_SEQ_SAT_EN
        if (acc > max_v) begin
            return max_v;
        end else if (acc < min_v) begin
            return min_v;
        end else begin
            return acc;
        end
`else
        if (max_v == min_v) begin
            return min_v;
        end else begin
            return acc;
        end
`endif
    endfunction

    logic [1:0]              state_q,   state_d;
    logic                    rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [7:0]              cnt_q,     cnt_d;
    logic                    dp_en_q,   dp_en_d;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
    logic                    busy_q,    busy_d;
    logic                    valid_q,   valid_d;
    logic signed [ACC_W-1:0] dp_ext_s;

    assign dp_ext_s = {{(ACC_W-21){iDp_Result[20]}}, iDp_Result};

    // Next-state, read-issue, accumulate and result-capture logic.
    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        // Datapath enable follows the read strobe by one cycle (memory latency).
        dp_en_d   = rd_en_q;
        acc_out_d = acc_out_q;
        if (dp_en_q) begin
            acc_d = acc_q + dp_ext_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    acc_d     = {ACC_W{1'b0}};
                    acc_out_d = {ACC_W{1'b0}};
                    rd_addr_d = iBase;
                    if (iLen != 8'd0) begin
                        state_d = S_RUN;
                        rd_en_d = 1'b1;
                        // cnt holds the number of reads still to issue after this one.
                        cnt_d   = iLen - 8'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                    dp_en_d = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d     = cnt_q - 8'd1;
                end
            end
            S_DRAIN: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                    dp_en_d = 1'b0;
                end else begin
                    // acc_d already includes the final chunk accumulated this cycle.
                    state_d   = S_DONE;
                    acc_out_d = shape_result(acc_d);
                end
            end
            S_DONE: begin
                if (iReady) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dp_en_d = 1'b0;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            cnt_q     <= 8'd0;
            dp_en_q   <= 1'b0;
            acc_q     <= {ACC_W{1'b0}};
            acc_out_q <= {ACC_W{1'b0}};
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            dp_en_q   <= dp_en_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    // Operands pass straight from memory to the datapath only while enabled.
    always_comb begin
        if (dp_en_q) begin
            oDp_XH = iRdXH;
            oDp_W  = iRdW;
        end else begin
            oDp_XH = 144'd0;
            oDp_W  = 144'd0;
        end
    end

    assign oRdEn   = rd_en_q;
    assign oRdAddr = rd_addr_q;
    assign oDp_En  = dp_en_q;
    assign oBusy   = busy_q;
    assign oValid  = valid_q;
    assign oAcc    = acc_out_q;

endmodule

// File: tb/tb_inpdt_seq.sv
// Directed testbench for inpdt_seq with scoreboard queues for read addresses,
// datapath operands and final results.
module tb_inpdt_seq;

    logic               iClk = 1'b0;
    logic               iRst = 1'b0;
    logic               iStart = 1'b0;
    logic [7:0]         iBase = 8'd0;
    logic [7:0]         iLen = 8'd0;
    logic               iAbort = 1'b0;
    logic               oRdEn;
    logic [7:0]         oRdAddr;
    logic [143:0]       iRdXH = 144'd0;
    logic [143:0]       iRdW = 144'd0;
    logic [143:0]       oDp_XH;
    logic [143:0]       oDp_W;
    logic               oDp_En;
    logic signed [20:0] iDp_Result;
    logic               oBusy;
    logic               oValid;
    logic               iReady = 1'b1;
    logic signed [28:0] oAcc;

    int checks = 0;
    int errors = 0;

    logic [7:0]         exp_addr[$];
    logic [7:0]         dp_q[$];
    longint             exp_acc[$];
    logic signed [20:0] res_mem[256];
    logic [7:0]         mon_a;
    int                 n;

    inpdt_seq dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBase(iBase), .iLen(iLen),
        .iAbort(iAbort), .oRdEn(oRdEn), .oRdAddr(oRdAddr), .iRdXH(iRdXH),
        .iRdW(iRdW), .oDp_XH(oDp_XH), .oDp_W(oDp_W), .oDp_En(oDp_En),
        .iDp_Result(iDp_Result), .oBusy(oBusy), .oValid(oValid),
        .iReady(iReady), .oAcc(oAcc)
    );

    always #5 iClk = ~iClk;

    // Operand memory: lane 0 of XH carries the address, lane 0 of W its complement.
    always @(posedge iClk) begin
        if (oRdEn) begin
            iRdXH <= {136'd0, oRdAddr};
            iRdW  <= {136'd0, ~oRdAddr};
        end
    end

    // Datapath stand-in: result looked up by the address tag in the operands.
    assign iDp_Result = (oDp_W[7:0] == ~oDp_XH[7:0]) ? res_mem[oDp_XH[7:0]] : 21'sh0AAAA;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_valid(input int start_n, input int bound, output int cnt);
        cnt = start_n;
        while (oValid !== 1'b1 && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge iClk) begin
        if (oDp_En) begin
            if (dp_q.size() == 0) begin
                chk("dp_unexpected", 64'(oDp_En), 64'd0);
            end else begin
                mon_a = dp_q.pop_front();
                chk("dp_xh_tag", 64'(oDp_XH[7:0]), 64'(mon_a));
            end
        end else begin
            chk("dp_xh_zero", 64'(|oDp_XH), 64'd0);
            chk("dp_w_zero", 64'(|oDp_W), 64'd0);
        end
        if (oRdEn) begin
            if (exp_addr.size() == 0) begin
                chk("rd_unexpected", 64'(oRdEn), 64'd0);
            end else begin
                mon_a = exp_addr.pop_front();
                chk("rd_addr", 64'(oRdAddr), 64'(mon_a));
                dp_q.push_back(mon_a);
            end
        end
        if (oValid) begin
            if (exp_acc.size() == 0) begin
                chk("valid_unexpected", 64'(oValid), 64'd0);
            end else begin
                chk("acc", 64'(oAcc), 64'(exp_acc[0]));
                if (iReady) begin
                    void'(exp_acc.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) res_mem[i] = 21'sd0;
        #1 iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_rden", 64'(oRdEn), 64'd0);
        chk("rst_addr", 64'(oRdAddr), 64'd0);
        chk("rst_dpen", 64'(oDp_En), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_valid", 64'(oValid), 64'd0);
        chk("rst_acc", 64'(oAcc), 64'd0);
        iRst = 1'b0;
        step();

        // Basic job: 100 - 50 + 7, iStart/iBase/iLen disturbed while running.
        res_mem[8'h10] = 21'sd100; res_mem[8'h11] = -21'sd50; res_mem[8'h12] = 21'sd7;
        exp_addr.push_back(8'h10); exp_addr.push_back(8'h11); exp_addr.push_back(8'h12);
        exp_acc.push_back(57);
        iBase = 8'h10; iLen = 8'd3; iStart = 1'b1;
        step();
        chk("a_busy", 64'(oBusy), 64'd1);
        iBase = 8'h80; iLen = 8'd7;
        step();
        iStart = 1'b0;
        wait_valid(2, 20, n);
        chk("a_latency", 64'(n), 64'd5);
        // iStart in the handshake cycle must be ignored.
        iStart = 1'b1; iLen = 8'd0;
        step();
        iStart = 1'b0;
        chk("a_idle_busy", 64'(oBusy), 64'd0);
        chk("a_idle_valid", 64'(oValid), 64'd0);
        step();
        chk("a_idle2_valid", 64'(oValid), 64'd0);

        // Zero-length job.
        exp_acc.push_back(0);
        iLen = 8'd0; iStart = 1'b1;
        step();
        iStart = 1'b0;
        chk("z_valid", 64'(oValid), 64'd1);
        chk("z_rden", 64'(oRdEn), 64'd0);
        step();
        chk("z_after_valid", 64'(oValid), 64'd0);

        // Address wrap with result held while iReady is low; abort in DONE ignored.
        iReady = 1'b0;
        res_mem[8'hFF] = 21'sd3; res_mem[8'h00] = -21'sd4;
        exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
        exp_acc.push_back(-1);
        iBase = 8'hFF; iLen = 8'd2; iStart = 1'b1;
        step();
        iStart = 1'b0;
        wait_valid(1, 20, n);
        chk("c_latency", 64'(n), 64'd4);
        iAbort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("c_hold_valid", 64'(oValid), 64'd1);
        end
        iAbort = 1'b0;
        iReady = 1'b1;
        step();
        chk("c_release_valid", 64'(oValid), 64'd0);
        chk("c_release_busy", 64'(oBusy), 64'd0);

        // Abort in the second RUN cycle.
        exp_addr.push_back(8'h40); exp_addr.push_back(8'h41);
        iBase = 8'h40; iLen = 8'd4; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        chk("ab_rden", 64'(oRdEn), 64'd0);
        chk("ab_dpen", 64'(oDp_En), 64'd0);
        chk("ab_busy", 64'(oBusy), 64'd0);
        chk("ab_valid", 64'(oValid), 64'd0);
        dp_q.delete();
        repeat (4) step();
        chk("ab_no_valid", 64'(oValid), 64'd0);

        // Normal job after the abort.
        res_mem[8'h50] = 21'sd11; res_mem[8'h51] = 21'sd22;
        exp_addr.push_back(8'h50); exp_addr.push_back(8'h51);
        exp_acc.push_back(33);
        iBase = 8'h50; iLen = 8'd2; iStart = 1'b1;
        step();
        iStart = 1'b0;
        wait_valid(1, 20, n);
        chk("e_latency", 64'(n), 64'd4);
        step();

        // Long job: 200 x 1000000.
        for (int i = 0; i < 256; i++) res_mem[i] = 21'sd1000000;
        for (int k = 0; k < 200; k++) exp_addr.push_back(8'(8'h60 + k));
`ifdef INPDT_SEQ_SAT_EN
        exp_acc.push_back(32767);
`else
        exp_acc.push_back(200000000);
`endif
        iBase = 8'h60; iLen = 8'd200; iStart = 1'b1;
        step();
        iStart = 1'b0;
        wait_valid(1, 400, n);
        chk("f_latency", 64'(n), 64'd202);
        step();

        // Asynchronous reset in the middle of a job; iStart during RUN ignored.
        for (int k = 0; k < 10; k++) exp_addr.push_back(8'(8'h30 + k));
        iBase = 8'h30; iLen = 8'd10; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        iStart = 1'b1; iBase = 8'h99; iLen = 8'd1;
        step();
        iStart = 1'b0;
        #2 iRst = 1'b1;
        #1;
        chk("mr_rden", 64'(oRdEn), 64'd0);
        chk("mr_addr", 64'(oRdAddr), 64'd0);
        chk("mr_dpen", 64'(oDp_En), 64'd0);
        chk("mr_xh", 64'(|oDp_XH), 64'd0);
        chk("mr_w", 64'(|oDp_W), 64'd0);
        chk("mr_busy", 64'(oBusy), 64'd0);
        chk("mr_valid", 64'(oValid), 64'd0);
        chk("mr_acc", 64'(oAcc), 64'd0);
        exp_addr.delete();
        dp_q.delete();
        step();
        iRst = 1'b0;
        step();
        chk("mr_after_busy", 64'(oBusy), 64'd0);

        // Recovery job after reset; accumulator must start from zero.
        res_mem[8'h70] = -21'sd9;
        exp_addr.push_back(8'h70);
        exp_acc.push_back(-9);
        iBase = 8'h70; iLen = 8'd1; iStart = 1'b1;
        step();
        iStart = 1'b0;
        wait_valid(1, 20, n);
        chk("h_latency", 64'(n), 64'd3);
        repeat (2) step();

        chk("queues_empty", 64'(exp_addr.size() + dp_q.size() + exp_acc.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inpdt_seq.md
INPDT_SEQ -- requirements
Module: inpdt_seq

Interface
REQ-001 Parameter ADDR_W, default 8: operand-memory address width.
REQ-002 Parameter ACC_W, default 29: accumulator/result width (21 + 8 bits of growth for 255 chunks).
REQ-003 iClk  input  1  sole clock; all state on rising edge.
REQ-004 iRst  input  1  reset, asynchronous, active-high.
REQ-005 iStart  input  1  job request; sampled only in IDLE.
REQ-006 iBase  input  ADDR_W  first chunk address, captured with iStart.
REQ-007 iLen  input  8  chunk count (16 elements each), captured with iStart.
REQ-008 iAbort  input  1  cancels the running job.
REQ-009 oRdEn  output  1  operand-memory read strobe.
REQ-010 oRdAddr  output  ADDR_W  read address.
REQ-011 iRdXH, iRdW  input  144 each  read data (16 x 9b signed), valid exactly 1 cycle after oRdEn.
REQ-012 oDp_XH, oDp_W  output  144 each  operands to the 16-lane inner-product datapath.
REQ-013 oDp_En  output  1  datapath input enable.
REQ-014 iDp_Result  input  21  signed datapath result, combinational from oDp_*.
REQ-015 oBusy  output  1  high in any state except IDLE.
REQ-016 oValid, iReady  output/input  1 each  result handshake.
REQ-017 oAcc  output  ACC_W  signed dot-product result.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on iStart with iLen!=0; IDLE->DONE on iStart with iLen==0 (oAcc=0).
REQ-019 RUN: oRdEn=1 each cycle, oRdAddr=iBase+k for k=0..iLen-1, one per cycle; after last issue go to DRAIN.
REQ-020 Address increments modulo 2^ADDR_W (base 0xFE, len 4 -> 0xFE,0xFF,0x00,0x01).
REQ-021 oDp_XH/oDp_W = iRdXH/iRdW and oDp_En=1 in the cycle after each read issue; otherwise oDp_En=0 and oDp_XH/oDp_W=0.
REQ-022 Each cycle with oDp_En=1 the accumulator adds sign-extended iDp_Result; accumulator clears on job acceptance.
REQ-023 DRAIN lasts 1 cycle (last accumulate), then DONE; iStart-to-oValid latency = iLen+2 cycles.
REQ-024 DONE: oValid=1, oAcc stable until the cycle iReady=1, then IDLE; iStart in that same cycle is ignored.
REQ-025 iStart ignored outside IDLE; iLen/iBase changes after capture have no effect.
REQ-026 iAbort in RUN/DRAIN: next state IDLE, oRdEn/oDp_En drop next cycle, no oValid; iAbort in IDLE/DONE ignored.
REQ-027 Throughput: one chunk per cycle, no bubbles inside a job.

Reset
REQ-028 iRst asynchronously forces IDLE, accumulator=0, oRdEn=0, oRdAddr=0, oDp_En=0, oDp_XH=oDp_W=0, oBusy=0, oValid=0, oAcc=0, including mid-job.

Configuration
REQ-029 Macro INPDT_SEQ_SAT_EN defined: oAcc in DONE is the accumulator clamped to [-32768, 32767], sign-extended to ACC_W.
REQ-030 Macro undefined: oAcc equals the full accumulator, no clamping.

Verification
REQ-031 iBase=0x10, iLen=3, iDp_Result 100,-50,7 -> reads 0x10..0x12, oValid at start+5, oAcc=57.
REQ-032 iLen=0 -> no oRdEn, oValid next cycle, oAcc=0.
REQ-033 iBase=0xFF, iLen=2, hold iReady=0 5 cycles -> addresses 0xFF,0x00; oValid/oAcc held until iReady.
REQ-034 iLen=4, iAbort at second RUN cycle -> oRdEn low next cycle, oBusy=0, no oValid; new job then runs normally.
REQ-035 iLen=200, iDp_Result=+1000000 each -> oAcc=200000000 without macro; 32767 with INPDT_SEQ_SAT_EN.
REQ-036 iRst pulsed mid-RUN -> all outputs zero immediately; iStart during RUN ignored.
